// File: rtl/vc_fifo_pkg.sv
// Shared types and helpers for the multi-VC synchronous FIFO.
package vc_fifo_pkg;

  localparam int unsigned VC_IDX_W  = 8;
  localparam int unsigned CNT_MAX_W = 16;

  // Widest VC index / occupancy supported by the FIFO family.
  typedef logic [VC_IDX_W-1:0]  vc_idx_t;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // Pointer increment that wraps at an arbitrary depth, not at a power of two.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-VC pointer, occupancy and flag tracking; one instance per virtual channel.
module vc_fifo_ctrl
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned PTR_W     = $clog2(DEPTH),
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_ok_i,
  input  logic             rd_ok_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_c_o,
  output logic             empty_c_o,
  output logic             almost_full_c_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_i) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_ok_i) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
    // Simultaneous accepted write and read leave occupancy unchanged.
    if (wr_ok_i && !rd_ok_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_ok_i && rd_ok_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o        = wr_ptr_q;
  assign rd_ptr_o        = rd_ptr_q;
  assign count_o         = count_q;
  assign full_c_o        = (count_q == CNT_W'(DEPTH));
  assign empty_c_o       = (count_q == '0);
  assign almost_full_c_o = (count_q >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/vc_sync_fifo.sv
// Multi-VC synchronous FIFO: shared write/read ports, per-VC queues, flags, counts and error pulses.
module vc_sync_fifo
  import vc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned FWFT      = 0,
  localparam int unsigned VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    WR_EN,
  input  logic [VC_W-1:0]         WR_VC,
  input  logic [WIDTH-1:0]        DATA_IN,
  input  logic                    RD_EN,
  input  logic [VC_W-1:0]         RD_VC,
  output logic [WIDTH-1:0]        DATA_OUT,
  output logic                    RD_VALID,
  output logic [NUM_VC-1:0]       FULL,
  output logic [NUM_VC-1:0]       EMPTY,
  output logic [NUM_VC-1:0]       ALMOST_FULL,
  output logic [NUM_VC*CNT_W-1:0] COUNT,
  output logic                    WR_OVF,
  output logic                    RD_UNF
);

  // Per-VC views padded to the full index range; padding VCs look full and empty.
  localparam int unsigned NVC_P = 1 << VC_W;

  logic [PTR_W-1:0] wr_ptr [NVC_P];
  logic [PTR_W-1:0] rd_ptr [NVC_P];
  logic [WIDTH-1:0] head   [NVC_P];
  logic [NVC_P-1:0] full_p;
  logic [NVC_P-1:0] empty_p;
  logic [NVC_P-1:0] wr_sel;
  logic [NVC_P-1:0] rd_sel;

  logic             rd_ok;
  logic             wr_ok;
  logic             wr_ovf_q;
  logic             rd_unf_q;
  logic [WIDTH-1:0] head_sel;

  // Accept arbitration: a full VC only takes a write alongside a pop of itself.
  always_comb begin
    rd_ok  = RD_EN & ~empty_p[RD_VC];
    wr_ok  = WR_EN & (~full_p[WR_VC] | (rd_ok & (RD_VC == WR_VC)));
    wr_sel = '0;
    rd_sel = '0;
    if (wr_ok) wr_sel[WR_VC] = 1'b1;
    if (rd_ok) rd_sel[RD_VC] = 1'b1;
    head_sel = head[RD_VC];
  end

  for (genvar v = 0; v < int'(NVC_P); v++) begin : g_vc
    if (v < int'(NUM_VC)) begin : g_real
      logic [WIDTH-1:0] mem_q [DEPTH];

      vc_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
      ) u_ctrl (
        .clk_i           (CLK),
        .rst_ni          (RSTn),
        .wr_ok_i         (wr_sel[v]),
        .rd_ok_i         (rd_sel[v]),
        .wr_ptr_o        (wr_ptr[v]),
        .rd_ptr_o        (rd_ptr[v]),
        .count_o         (COUNT[v*CNT_W +: CNT_W]),
        .full_c_o        (full_p[v]),
        .empty_c_o       (empty_p[v]),
        .almost_full_c_o (ALMOST_FULL[v])
      );

      // Storage is intentionally not reset; pointers define what is valid.
      always_ff @(posedge CLK) begin
        if (wr_sel[v]) mem_q[wr_ptr[v]] <= DATA_IN;
      end

      assign head[v]  = mem_q[rd_ptr[v]];
      assign FULL[v]  = full_p[v];
      assign EMPTY[v] = empty_p[v];
    end else begin : g_pad
      assign wr_ptr[v]  = '0;
      assign rd_ptr[v]  = '0;
      assign head[v]    = '0;
      assign full_p[v]  = 1'b1;
      assign empty_p[v] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
    end else begin
      wr_ovf_q <= WR_EN & ~wr_ok;
      rd_unf_q <= RD_EN & ~rd_ok;
    end
  end

  assign WR_OVF = wr_ovf_q;
  assign RD_UNF = rd_unf_q;

  if (FWFT == 0) begin : g_rd_reg
    logic [WIDTH-1:0] dout_q;
    logic             rd_valid_q;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) dout_q <= head_sel;
      end
    end

    assign DATA_OUT = dout_q;
    assign RD_VALID = rd_valid_q;
  end else begin : g_rd_fwft
    assign DATA_OUT = head_sel;
    assign RD_VALID = ~empty_p[RD_VC];
  end

endmodule

// File: tb/tb_vc_sync_fifo.sv
// Self-checking bench: registered-read and FWFT instances share stimulus and one queue model.
module tb_vc_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int NV = 4;
  localparam int AF = 14;
  localparam int CW = 5;

  logic          CLK;
  logic          RSTn;
  logic          WR_EN, RD_EN;
  logic [1:0]    WR_VC, RD_VC;
  logic [W-1:0]  DATA_IN;

  logic [W-1:0]     d0_dout, d1_dout;
  logic             d0_rv, d1_rv;
  logic [NV-1:0]    d0_full, d1_full, d0_empty, d1_empty, d0_af, d1_af;
  logic [NV*CW-1:0] d0_count, d1_count;
  logic             d0_ovf, d1_ovf, d0_unf, d1_unf;

  vc_sync_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV), .AF_THRESH(AF), .FWFT(0)) u_reg (
    .CLK(CLK), .RSTn(RSTn), .WR_EN(WR_EN), .WR_VC(WR_VC), .DATA_IN(DATA_IN),
    .RD_EN(RD_EN), .RD_VC(RD_VC), .DATA_OUT(d0_dout), .RD_VALID(d0_rv),
    .FULL(d0_full), .EMPTY(d0_empty), .ALMOST_FULL(d0_af), .COUNT(d0_count),
    .WR_OVF(d0_ovf), .RD_UNF(d0_unf)
  );

  vc_sync_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV), .AF_THRESH(AF), .FWFT(1)) u_fwft (
    .CLK(CLK), .RSTn(RSTn), .WR_EN(WR_EN), .WR_VC(WR_VC), .DATA_IN(DATA_IN),
    .RD_EN(RD_EN), .RD_VC(RD_VC), .DATA_OUT(d1_dout), .RD_VALID(d1_rv),
    .FULL(d1_full), .EMPTY(d1_empty), .ALMOST_FULL(d1_af), .COUNT(d1_count),
    .WR_OVF(d1_ovf), .RD_UNF(d1_unf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q [NV][$];
  logic         exp_v0;
  logic [W-1:0] exp_d0;
  logic         exp_ovf, exp_unf;
  int           cur_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the queue model.
  task automatic compare_outputs();
    logic [NV*CW-1:0] ec;
    logic [NV-1:0]    ef, ee, ea;
    logic             hv;
    for (int v = 0; v < NV; v++) begin
      ec[v*CW +: CW] = CW'(q[v].size());
      ef[v] = (q[v].size() == D);
      ee[v] = (q[v].size() == 0);
      ea[v] = (q[v].size() >= AF);
    end
    chk("count_reg", d0_count, ec);    chk("count_fwft", d1_count, ec);
    chk("full_reg", d0_full, ef);      chk("full_fwft", d1_full, ef);
    chk("empty_reg", d0_empty, ee);    chk("empty_fwft", d1_empty, ee);
    chk("afull_reg", d0_af, ea);       chk("afull_fwft", d1_af, ea);
    chk("ovf_reg", d0_ovf, exp_ovf);   chk("ovf_fwft", d1_ovf, exp_ovf);
    chk("unf_reg", d0_unf, exp_unf);   chk("unf_fwft", d1_unf, exp_unf);
    chk("rvalid_reg", d0_rv, exp_v0);
    if (exp_v0) chk("dout_reg", d0_dout, exp_d0);
    hv = (q[cur_rv].size() != 0);
    chk("rvalid_fwft", d1_rv, hv);
    if (hv) chk("dout_fwft", d1_dout, q[cur_rv][0]);
  endtask

  // One clock of stimulus: drive at negedge, check, then apply the model at the edge.
  task automatic step(input logic we, input int wv, input logic [W-1:0] d,
                      input logic re, input int rv);
    logic rd_ok, wr_ok;
    logic [W-1:0] popped;
    WR_EN = we; WR_VC = 2'(wv); DATA_IN = d;
    RD_EN = re; RD_VC = 2'(rv); cur_rv = rv;
    #1;
    compare_outputs();
    rd_ok = re && (q[rv].size() != 0);
    wr_ok = we && ((q[wv].size() < D) || (rd_ok && rv == wv));
    popped = '0;
    @(posedge CLK);
    if (rd_ok) popped = q[rv].pop_front();
    if (wr_ok) q[wv].push_back(d);
    exp_v0  = rd_ok;
    if (rd_ok) exp_d0 = popped;
    exp_ovf = we && !wr_ok;
    exp_unf = re && !rd_ok;
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, d0_count, '0);
    chk({tag, "_empty"}, d0_empty, 4'hF);
    chk({tag, "_full"},  d0_full, '0);
    chk({tag, "_afull"}, d0_af, '0);
    chk({tag, "_ovf"},   d0_ovf, 1'b0);
    chk({tag, "_unf"},   d0_unf, 1'b0);
    chk({tag, "_rv"},    d0_rv, 1'b0);
    chk({tag, "_dout"},  d0_dout, '0);
    chk({tag, "_rv_fwft"}, d1_rv, 1'b0);
    chk({tag, "_empty_fwft"}, d1_empty, 4'hF);
  endtask

  task automatic clear_model();
    for (int v = 0; v < NV; v++) q[v].delete();
    exp_v0 = 1'b0; exp_d0 = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; WR_VC = '0; RD_VC = '0; DATA_IN = '0;
    cur_rv = 0;
    clear_model();
    #12;
    check_reset_values("init");
    @(negedge CLK);
    RSTn = 1'b1;

    // Basic ordered write/read on VC2.
    step(1, 2, 8'h11, 0, 0);
    step(1, 2, 8'h22, 0, 0);
    step(1, 2, 8'h33, 0, 0);
    #1 chk("lit_cnt2_3", d0_count[2*CW +: CW], 32'd3);
    step(0, 0, 8'h00, 1, 2);
    #1 chk("lit_d11", d0_dout, 8'h11); chk("lit_rv_after_rd", d0_rv, 1'b1);
    step(0, 0, 8'h00, 1, 2);
    #1 chk("lit_d22", d0_dout, 8'h22);
    step(0, 0, 8'h00, 1, 2);
    #1 chk("lit_d33", d0_dout, 8'h33);
    chk("lit_cnt2_0", d0_count[2*CW +: CW], 32'd0);
    chk("lit_empty2", d0_empty[2], 1'b1);

    // Fill VC1 to the threshold and to full, then overflow.
    for (int i = 0; i < D; i++) begin
      step(1, 1, 8'(8'h40 + i), 0, 0);
      #1;
      if (i == 12) chk("lit_af1_13", d0_af[1], 1'b0);
      if (i == 13) chk("lit_af1_14", d0_af[1], 1'b1);
      if (i == 14) chk("lit_full1_15", d0_full[1], 1'b0);
      if (i == 15) chk("lit_full1_16", d0_full[1], 1'b1);
    end
    step(1, 1, 8'hEE, 0, 0);
    #1 chk("lit_ovf", d0_ovf, 1'b1); chk("lit_cnt1_16", d0_count[1*CW +: CW], 32'd16);

    // Write-through on a full VC with a same-cycle pop; wraps both pointers.
    step(1, 1, 8'hAA, 1, 1);
    #1 chk("lit_wt_cnt", d0_count[1*CW +: CW], 32'd16);
    chk("lit_wt_dout", d0_dout, 8'h40);
    chk("lit_wt_noovf", d0_ovf, 1'b0);
    for (int i = 0; i < D - 1; i++) step(0, 0, 8'h00, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    #1 chk("lit_aa_last", d0_dout, 8'hAA); chk("lit_cnt1_0", d0_count[1*CW +: CW], 32'd0);

    // Read of an empty VC is rejected even with a same-cycle write.
    step(1, 0, 8'h5A, 1, 0);
    #1 chk("lit_unf", d0_unf, 1'b1); chk("lit_unf_rv", d0_rv, 1'b0);
    chk("lit_cnt0_1", d0_count[0 +: CW], 32'd1);
    step(0, 0, 8'h00, 1, 0);
    #1 chk("lit_d5a", d0_dout, 8'h5A); chk("lit_d5a_rv", d0_rv, 1'b1);

    // Interleaved write VC3 / read VC0 traffic.
    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 3, 8'($urandom), 1, 0);

    // Random mixed traffic across all VCs.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, NV - 1), 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, NV - 1));

    // Drain, build COUNT[2] = 5, then reset asynchronously mid-burst.
    for (int v = 0; v < NV; v++)
      for (int i = 0; i < D + 2; i++)
        if (q[v].size() != 0) step(0, 0, 8'h00, 1, v);
    for (int i = 0; i < 5; i++) step(1, 2, 8'(8'hC0 + i), 0, 0);
    #1 chk("lit_cnt2_5", d0_count[2*CW +: CW], 32'd5);
    WR_EN = 1'b1; WR_VC = 2'd2; DATA_IN = 8'hD0; RD_EN = 1'b1; RD_VC = 2'd2; cur_rv = 2;
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1 check_reset_values("mid");
    WR_EN = 1'b0; RD_EN = 1'b0;
    clear_model();
    @(negedge CLK);
    RSTn = 1'b1;
    step(1, 2, 8'h77, 0, 2);
    #1 chk("lit_fwft_rv_resume", d1_rv, 1'b1); chk("lit_fwft_d_resume", d1_dout, 8'h77);
    step(1, 2, 8'h78, 1, 2);
    step(0, 0, 8'h00, 1, 2);
    step(0, 0, 8'h00, 0, 2);
    step(0, 0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_sync_fifo.md
# vc_sync_fifo

Multi-channel synchronous FIFO for the router input port: NUM_VC independent virtual-channel queues, each DEPTH words of WIDTH bits, behind one shared write port and one shared read port. It is the next generation of the single-queue synchronous FIFO. It adds:
- per-VC flags and occupancy counts,
- an almost-full threshold for credit/back-pressure logic,
- write-through-when-full on the same VC,
- selectable standard or first-word-fall-through (FWFT) read mode,
- overflow/underflow error pulses.

## Interface
Parameters:
- WIDTH, 8, data bits per word
- DEPTH, 16, words per VC (any value ≥ 2; need not be a power of 2)
- NUM_VC, 4, number of virtual channels (≥ 1)
- AF_THRESH, DEPTH-2, ALMOST_FULL asserts when count ≥ AF_THRESH (1..DEPTH)
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = head word visible combinationally
- derived: VC_W = max(1,$clog2(NUM_VC)), PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- WR_EN  in  1  write request
- WR_VC  in  VC_W  target VC of the write
- DATA_IN  in  WIDTH  write data
- RD_EN  in  1  read (pop) request
- RD_VC  in  VC_W  VC to read
- DATA_OUT  out  WIDTH  read data
- RD_VALID  out  1  DATA_OUT holds a valid popped/head word
- FULL  out  NUM_VC  per-VC full (count == DEPTH)
- EMPTY  out  NUM_VC  per-VC empty (count == 0)
- ALMOST_FULL  out  NUM_VC  per-VC count ≥ AF_THRESH
- COUNT  out  NUM_VC*CNT_W  per-VC occupancy; VC i is in bits [i*CNT_W +: CNT_W]
- WR_OVF  out  1  one-cycle pulse: a write was rejected the previous cycle
- RD_UNF  out  1  one-cycle pulse: a read was rejected the previous cycle

## Operation
- Read accept: rd_ok = RD_EN & ~EMPTY[RD_VC].
- Write accept: wr_ok = WR_EN & (~FULL[WR_VC] | (rd_ok & RD_VC == WR_VC)).
- Write on a full VC is accepted only with a same-cycle pop of that VC.
- Read of an empty VC is always rejected, even with a same-cycle write to it. There is no bypass; the word is stored.
- Pointers per VC: wr_ptr advances on wr_ok and rd_ptr advances on rd_ok. Both wrap from DEPTH-1 to 0 by compare, not by bit overflow.
- COUNT[v]:
  - +1 on write only
  - −1 on read only
  - unchanged on simultaneous accepted write and read of v
  - writes and reads to different VCs update each VC independently
- Flags FULL, EMPTY, ALMOST_FULL are combinational decodes of the registered counts.
- FWFT=0:
  - on rd_ok, the head of RD_VC is registered into DATA_OUT and RD_VALID=1 the next cycle.
  - with no rd_ok, RD_VALID=0 next cycle and DATA_OUT holds its last value.
- FWFT=1:
  - DATA_OUT = head word of RD_VC (combinational mux from storage).
  - RD_VALID = ~EMPTY[RD_VC].
  - RD_EN with RD_VALID pops that word.
- Errors:
  - WR_EN & ~wr_ok → WR_OVF=1 next cycle.
  - RD_EN & ~rd_ok → RD_UNF=1 next cycle.
  - Both are single-cycle, non-sticky pulses.
- Out-of-range VC index (≥ NUM_VC): treated as a rejected request and flagged via WR_OVF/RD_UNF.

## Timing
- Reset (asynchronous, any time including mid-transfer):
  - all pointers and counts go to 0; EMPTY = all 1; FULL and ALMOST_FULL = 0.
  - WR_OVF = RD_UNF = 0; FWFT=0 DATA_OUT = 0, RD_VALID = 0.
  - storage contents are not cleared.
- Latency for FWFT=0:
  - write-to-flag: 1 cycle (the word is readable the cycle after its write edge).
  - read latency: 1 cycle.
- Latency for FWFT=1: write-to-RD_VALID is 1 cycle.
- Throughput: one write and one read per cycle, to the same or different VCs.

## Structure
- Shared package vc_fifo_pkg: VC index type, count type, and a function for pointer increment with wrap-at-DEPTH.
- Storage: one flop array [NUM_VC][DEPTH] of WIDTH, written at {WR_VC, wr_ptr}.
- One sub-module, vc_fifo_ctrl: per-VC pointer/count/flag logic, instantiated NUM_VC times in a generate loop.
- Top level holds the accept arbitration, storage, read mux/register and error pulses.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to VC2 and read VC2 three times (FWFT=0) → DATA_OUT 0x11, 0x22, 0x33 with RD_VALID one cycle after each RD_EN; COUNT[2] goes 3→0; EMPTY[2] = 1.
- Fill VC1 with 16 words (DEPTH=16, AF_THRESH=14) → ALMOST_FULL[1] rises after the 14th write, FULL[1] after the 16th. A 17th write alone → WR_OVF pulse, COUNT stays 16.
- VC1 full, then simultaneous write 0xAA to VC1 and read of VC1 → both accepted; COUNT stays 16; 0xAA emerges last after 15 further reads; wrap-around is exercised.
- VC0 empty, then simultaneous write 0x5A to VC0 and read of VC0 → read rejected (RD_UNF next cycle, RD_VALID=0); COUNT[0] = 1; next read returns 0x5A.
- Interleaved write to VC3 and read from VC0 every cycle for 40 cycles → per-VC order preserved and counts independent, checked against a scoreboard.
- Assert RSTn low asynchronously mid-burst with COUNT[2] = 5 → all outputs take reset values before the next edge. With FWFT=1, RD_VALID = 0 and writes resume normally after release.
